// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding, default frame shape
// and oversampling constants.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;
  localparam int MID_BIT     = 7;

  // Tick counter must hold OVERSAMPLE-1 even when the stop phase is short.
  function automatic int tick_cnt_width(input int sb_tick);
    return ($clog2(sb_tick) < 4) ? 4 : $clog2(sb_tick);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 16x oversampled 8N1-style UART receiver: deframes LSB-first characters,
// drops start-bit glitches and flags a low stop-bit sample as a framing error.
//
// state | meaning
// IDLE  | line idle, waiting for falling edge on i_rx
// START | counting to mid start bit, confirming it is still low
// DATA  | sampling one data bit every 16 ticks, shifting LSB first
// STOP  | waiting SB_TICK ticks, then pulsing done/frame_err
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err
);

  localparam int SW = tick_cnt_width(SB_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID      = SW'(MID_BIT);
  localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  state_t          r_state, w_state;
  logic [SW-1:0]   r_s, w_s;
  logic [NW-1:0]   r_n, w_n;
  logic [DBIT-1:0] r_b, w_b;
  logic            w_done;
  logic            w_ferr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state;
      r_s     <= w_s;
      r_n     <= w_n;
      r_b     <= w_b;
    end
  end

  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_done  = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Edge detect runs every clk so the start bit is caught before the next tick.
        if (!i_rx) begin
          w_state = ST_START;
          w_s     = '0;
        end
      end
      ST_START: begin
        if (i_s_tick) begin
          if (r_s == S_MID) begin
            if (!i_rx) begin
              w_state = ST_DATA;
              w_s     = '0;
              w_n     = '0;
            end else begin
              w_state = ST_IDLE;
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_s_tick) begin
          if (r_s == S_BIT_END) begin
            w_b = {i_rx, r_b[DBIT-1:1]};
            w_s = '0;
            if (r_n == N_LAST) begin
              w_state = ST_STOP;
            end else begin
              w_n = r_n + NW'(1);
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (i_s_tick) begin
          if (r_s == S_STOP_END) begin
            w_done  = 1'b1;
            w_ferr  = ~i_rx;
            w_state = ST_IDLE;
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign o_dout         = r_b;
  assign o_rx_done_tick = w_done;
  assign o_frame_err    = w_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a line driver pushes expected characters into a
// scoreboard, negedge monitors pop and compare on each done pulse.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int LAT = 152;  // ticks from start-bit drive to done, both DUT shapes

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic       rx, rx2;
  logic       s_tick;
  logic [7:0] dout;
  logic       done, ferr;
  logic [6:0] dout2;
  logic       done2, ferr2;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  int snap;

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    int         start;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  uart_rx dut (
    .i_clk(clk), .i_reset(reset), .i_rx(rx), .i_s_tick(s_tick),
    .o_dout(dout), .o_rx_done_tick(done), .o_frame_err(ferr)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
    .i_clk(clk), .i_reset(reset2), .i_rx(rx2), .i_s_tick(s_tick),
    .o_dout(dout2), .o_rx_done_tick(done2), .o_frame_err(ferr2)
  );

  always #10 clk = ~clk;

  // s_tick: one clk high every 27 clks; tick_cnt numbers each pulse.
  initial begin
    int div;
    div = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (div == 26) begin
        s_tick = 1'b1;
        div = 0;
        tick_cnt++;
      end else begin
        s_tick = 1'b0;
        div++;
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt1++;
      checks++;
      assert (q1.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done1 observed pulse expected none");
      end
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        checks++;
        assert (dout === e1.data[7:0]) else begin
          errors++;
          $error("FAIL dout1 observed %h expected %h", dout, e1.data[7:0]);
        end
        checks++;
        assert (ferr === e1.ferr) else begin
          errors++;
          $error("FAIL ferr1 observed %b expected %b", ferr, e1.ferr);
        end
        checks++;
        assert (tick_cnt - e1.start == LAT) else begin
          errors++;
          $error("FAIL latency1 observed %0d expected %0d", tick_cnt - e1.start, LAT);
        end
      end
    end
    if (ferr) begin
      checks++;
      assert (done === 1'b1) else begin
        errors++;
        $error("FAIL ferr1_alone observed done=%b expected 1", done);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      done_cnt2++;
      checks++;
      assert (q2.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done2 observed pulse expected none");
      end
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        checks++;
        assert (dout2 === e2.data[6:0]) else begin
          errors++;
          $error("FAIL dout2 observed %h expected %h", dout2, e2.data[6:0]);
        end
        checks++;
        assert (ferr2 === e2.ferr) else begin
          errors++;
          $error("FAIL ferr2 observed %b expected %b", ferr2, e2.ferr);
        end
        checks++;
        assert (tick_cnt - e2.start == LAT) else begin
          errors++;
          $error("FAIL latency2 observed %0d expected %0d", tick_cnt - e2.start, LAT);
        end
      end
    end
  end

  // Returns just after the edge that consumed the n-th tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #2;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 1) rx = v;
    else rx2 = v;
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int sb_ticks, input bit bad_stop, input int gap_ticks);
    exp_t e;
    e.data  = data;
    e.ferr  = bad_stop;
    e.start = tick_cnt;
    if (which == 1) q1.push_back(e);
    else q2.push_back(e);
    set_line(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, data[i]);
      wait_ticks(16);
    end
    if (bad_stop) begin
      set_line(which, 1'b0);
      wait_ticks(sb_ticks / 2);
      set_line(which, 1'b1);
      wait_ticks(sb_ticks - sb_ticks / 2);
    end else begin
      set_line(which, 1'b1);
      wait_ticks(sb_ticks);
    end
    wait_ticks(gap_ticks);
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    rx = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (dout === 8'h00 && done === 1'b0 && ferr === 1'b0) else begin
      errors++;
      $error("FAIL reset_outputs observed %h/%b/%b expected 00/0/0", dout, done, ferr);
    end
    checks++;
    assert (dut.r_state === ST_IDLE) else begin
      errors++;
      $error("FAIL reset_state observed %0d expected IDLE", dut.r_state);
    end
    reset = 1'b0;
    reset2 = 1'b0;
    wait_ticks(4);

    // 1) single 0xA5
    snap = done_cnt1;
    send_frame(1, 9'h0A5, 8, 16, 1'b0, 16);
    check_cnt("t1_pulses", done_cnt1 - snap, 1);
    checks++;
    assert (dout === 8'hA5 && dut.r_state === ST_IDLE) else begin
      errors++;
      $error("FAIL t1_hold observed %h/%0d expected a5/IDLE", dout, dut.r_state);
    end

    // 2) 0x00 then 0xFF, no idle gap
    snap = done_cnt1;
    send_frame(1, 9'h000, 8, 16, 1'b0, 0);
    send_frame(1, 9'h0FF, 8, 16, 1'b0, 16);
    check_cnt("t2_pulses", done_cnt1 - snap, 2);

    // 3) start glitch, then 0x3C
    snap = done_cnt1;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check_cnt("t3_glitch_pulses", done_cnt1 - snap, 0);
    check_cnt("t3_glitch_state", int'(dut.r_state), int'(ST_IDLE));
    send_frame(1, 9'h03C, 8, 16, 1'b0, 16);
    check_cnt("t3_pulses", done_cnt1 - snap, 1);

    // 4) 0x55 with low stop bit
    snap = done_cnt1;
    send_frame(1, 9'h055, 8, 16, 1'b1, 16);
    check_cnt("t4_pulses", done_cnt1 - snap, 1);

    // 5) reset during bit 4 of 0x81
    snap = done_cnt1;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      wait_ticks(16);
    end
    rx = 1'b0;
    wait_ticks(8);
    reset = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    assert (dout === 8'h00 && done === 1'b0 && ferr === 1'b0 && dut.r_state === ST_IDLE) else begin
      errors++;
      $error("FAIL t5_reset observed %h/%b/%b/%0d expected 00/0/0/IDLE",
             dout, done, ferr, dut.r_state);
    end
    reset = 1'b0;
    wait_ticks(20);
    check_cnt("t5_abort_pulses", done_cnt1 - snap, 0);
    send_frame(1, 9'h081, 8, 16, 1'b0, 16);
    check_cnt("t5_pulses", done_cnt1 - snap, 1);

    // 6) DBIT=7, SB_TICK=32 instance
    snap = done_cnt2;
    send_frame(2, 9'h02A, 7, 32, 1'b0, 16);
    check_cnt("t6_pulses", done_cnt2 - snap, 1);

    check_cnt("q1_left", q1.size(), 0);
    check_cnt("q2_left", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
